dm9000a_tx_engine: RTL and testbench

Parametrised DM9000A transmit controller for the ethernet test design. After power-up it runs a configurable register-init sequence. It then accepts packets of any length as a 16-bit word stream on a valid/ready handshake and pushes them into the MAC's TX SRAM through MWCMD. It polls TXREQ, programs TXPLL/TXPLH and issues TX. Every ISA-style bus cycle goes through a timing-parametrised bus-cycle sub-module, with separate strobe and recovery widths.

---
 rtl/dm9000a_pkg.sv | 38 +++
 rtl/dm9000a_bus_cycle.sv | 106 ++++++++++
 rtl/dm9000a_tx_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_dm9000a_tx_engine.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm9000a_pkg.sv
// Shared register map, FSM/bus phase encodings and helpers for the DM9000A TX engine.
package dm9000a_pkg;

  localparam logic [7:0] REG_TCR   = 8'h02;
  localparam logic [7:0] REG_GPR   = 8'h1F;
  localparam logic [7:0] REG_CSCR  = 8'h31;
  localparam logic [7:0] REG_MWCMD = 8'hF8;
  localparam logic [7:0] REG_TXPLL = 8'hFC;
  localparam logic [7:0] REG_TXPLH = 8'hFD;
  localparam logic [7:0] REG_IMR   = 8'hFF;

  localparam int unsigned TX_REQ_BIT  = 0;
  localparam logic [15:0] TX_REQ_MASK = 16'h0001 << TX_REQ_BIT;

  typedef enum logic [2:0] {
    ST_WAIT_PWR = 3'd0,
    ST_INIT     = 3'd1,
    ST_IDLE     = 3'd2,
    ST_MWCMD    = 3'd3,
    ST_DATA     = 3'd4,
    ST_POLL     = 3'd5,
    ST_LEN      = 3'd6,
    ST_ISSUE    = 3'd7
  } tx_state_e;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_STROBE  = 2'd1,
    PH_RECOVER = 2'd2
  } bus_phase_e;

  // A register write is an INDEX cycle carrying the address followed by a DATA cycle carrying the value.
  function automatic logic [15:0] reg_word(input logic is_data, input logic [7:0] addr,
                                           input logic [7:0] val);
    return {8'h00, (is_data ? val : addr)};
  endfunction

endpackage

// File: rtl/dm9000a_bus_cycle.sv
// One ISA-style read or write cycle to the DM9000A: strobe low, then recovery high.
module dm9000a_bus_cycle
  import dm9000a_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES   = 1,
  parameter int unsigned RECOVERY_CYCLES = 1
) (
  input  logic        clk_30,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rd,
  input  logic        cmd,
  input  logic [15:0] wdata,
  output logic        idle,
  output logic        cyc_done,
  output logic [15:0] rdata,
  output logic        enet_ior_n,
  output logic        enet_iow_n,
  output logic        enet_cmd,
  output logic        enet_data_oe,
  output logic [15:0] enet_data_out,
  input  logic [15:0] enet_data_in
);

  localparam logic [15:0] STROBE_LAST   = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] RECOVERY_LAST = 16'(RECOVERY_CYCLES - 1);

  bus_phase_e  phase_reg;
  logic [15:0] cnt_reg;
  logic        rd_reg;
  logic        ior_n_reg;
  logic        iow_n_reg;
  logic        cmd_reg;
  logic        oe_reg;
  logic [15:0] dout_reg;
  logic [15:0] rdata_reg;

  always_ff @(posedge clk_30 or negedge reset_n) begin
    if (!reset_n) begin
      phase_reg <= PH_IDLE;
      cnt_reg   <= 16'd0;
      rd_reg    <= 1'b0;
      ior_n_reg <= 1'b1;
      iow_n_reg <= 1'b1;
      cmd_reg   <= 1'b0;
      oe_reg    <= 1'b0;
      dout_reg  <= 16'h0000;
      rdata_reg <= 16'h0000;
    end else begin
      case (phase_reg)
        PH_IDLE: begin
          if (start) begin
            phase_reg <= PH_STROBE;
            cnt_reg   <= STROBE_LAST;
            rd_reg    <= rd;
            if (rd) begin
              ior_n_reg <= 1'b0;
              oe_reg    <= 1'b0;
              cmd_reg   <= 1'b1;
            end else begin
              iow_n_reg <= 1'b0;
              oe_reg    <= 1'b1;
              cmd_reg   <= cmd;
              dout_reg  <= wdata;
            end
          end
        end
        PH_STROBE: begin
          if (cnt_reg == 16'd0) begin
            // Read data is taken on the same edge that releases ior_n.
            ior_n_reg <= 1'b1;
            iow_n_reg <= 1'b1;
            phase_reg <= PH_RECOVER;
            cnt_reg   <= RECOVERY_LAST;
            if (rd_reg) begin
              rdata_reg <= enet_data_in;
            end
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        PH_RECOVER: begin
          if (cnt_reg == 16'd0) begin
            phase_reg <= PH_IDLE;
            oe_reg    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        default: begin
          phase_reg <= PH_IDLE;
        end
      endcase
    end
  end

  assign idle          = (phase_reg == PH_IDLE);
  assign cyc_done      = (phase_reg == PH_RECOVER) && (cnt_reg == 16'd0);
  assign rdata         = rdata_reg;
  assign enet_ior_n    = ior_n_reg;
  assign enet_iow_n    = iow_n_reg;
  assign enet_cmd      = cmd_reg;
  assign enet_data_oe  = oe_reg;
  assign enet_data_out = dout_reg;

endmodule

// File: rtl/dm9000a_tx_engine.sv
// DM9000A transmit controller: power-up wait, register init, then per packet
// MWCMD stream, TXREQ poll, length program and TX issue.
module dm9000a_tx_engine
  import dm9000a_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES  = 50000,
  parameter int unsigned STROBE_CYCLES   = 1,
  parameter int unsigned RECOVERY_CYCLES = 1,
  parameter logic [7:0]  IMR_VALUE       = 8'h80,
  parameter logic [7:0]  CSCR_VALUE      = 8'h05,
  parameter int unsigned MAX_LEN         = 1536,
  parameter int unsigned POLL_LIMIT      = 4096
) (
  input  logic        clk_30,
  input  logic        reset_n,
  input  logic        pkt_start,
  input  logic [10:0] pkt_len,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        init_done,
  output logic        busy,
  output logic        tx_err,
  output logic        enet_ior_n,
  output logic        enet_iow_n,
  output logic        enet_cmd,
  output logic        enet_data_oe,
  output logic [15:0] enet_data_out,
  input  logic [15:0] enet_data_in
);

  tx_state_e   state_reg;
  logic [2:0]  step_reg;
  logic [31:0] pwr_cnt_reg;
  logic [31:0] poll_cnt_reg;
  logic [10:0] len_reg;
  logic [10:0] words_reg;
  logic        init_done_reg;
  logic        busy_reg;
  logic        tx_err_reg;

  logic        bus_idle;
  logic        bus_done;
  logic [15:0] bus_rdata;
  logic        bus_start;
  logic        bus_rd;
  logic        bus_cmd;
  logic [15:0] bus_wdata;

  logic [11:0] len_plus1;
  logic        len_bad;
  logic        tx_req_pending;

  assign len_plus1      = {1'b0, pkt_len} + 12'd1;
  assign len_bad        = (pkt_len == 11'd0) || ({21'd0, pkt_len} > MAX_LEN);
  assign tx_req_pending = |(bus_rdata & TX_REQ_MASK);
  assign tx_ready       = (state_reg == ST_DATA) && bus_idle && (words_reg != 11'd0);

  // Bus request for the current state/step; a cycle is launched only while the bus is idle.
  always_comb begin
    bus_start = 1'b0;
    bus_rd    = 1'b0;
    bus_cmd   = 1'b0;
    bus_wdata = 16'h0000;
    case (state_reg)
      ST_INIT: begin
        bus_start = bus_idle;
        bus_cmd   = step_reg[0];
        case (step_reg[2:1])
          2'd0:    bus_wdata = reg_word(step_reg[0], REG_IMR, IMR_VALUE);
          2'd1:    bus_wdata = reg_word(step_reg[0], REG_GPR, 8'h00);
          default: bus_wdata = reg_word(step_reg[0], REG_CSCR, CSCR_VALUE);
        endcase
      end
      ST_MWCMD: begin
        bus_start = bus_idle;
        bus_wdata = reg_word(1'b0, REG_MWCMD, 8'h00);
      end
      ST_DATA: begin
        bus_start = tx_ready && tx_valid;
        bus_cmd   = 1'b1;
        bus_wdata = tx_data;
      end
      ST_POLL: begin
        bus_start = bus_idle;
        if (step_reg == 3'd0) begin
          bus_wdata = reg_word(1'b0, REG_TCR, 8'h00);
        end else begin
          bus_rd  = 1'b1;
          bus_cmd = 1'b1;
        end
      end
      ST_LEN: begin
        bus_start = bus_idle;
        bus_cmd   = step_reg[0];
        if (step_reg[1]) begin
          bus_wdata = reg_word(step_reg[0], REG_TXPLH, {5'b00000, len_reg[10:8]});
        end else begin
          bus_wdata = reg_word(step_reg[0], REG_TXPLL, len_reg[7:0]);
        end
      end
      ST_ISSUE: begin
        bus_start = bus_idle;
        bus_cmd   = step_reg[0];
        bus_wdata = reg_word(step_reg[0], REG_TCR, 8'h01);
      end
      default: begin
        bus_start = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_30 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_WAIT_PWR;
      step_reg      <= 3'd0;
      pwr_cnt_reg   <= 32'd0;
      poll_cnt_reg  <= 32'd0;
      len_reg       <= 11'd0;
      words_reg     <= 11'd0;
      init_done_reg <= 1'b0;
      busy_reg      <= 1'b0;
      tx_err_reg    <= 1'b0;
    end else begin
      tx_err_reg <= 1'b0;
      case (state_reg)
        ST_WAIT_PWR: begin
          if ((pwr_cnt_reg + 32'd1) >= POWERUP_CYCLES) begin
            state_reg <= ST_INIT;
            step_reg  <= 3'd0;
          end else begin
            pwr_cnt_reg <= pwr_cnt_reg + 32'd1;
          end
        end
        ST_INIT: begin
          if (bus_done) begin
            if (step_reg == 3'd5) begin
              state_reg     <= ST_IDLE;
              step_reg      <= 3'd0;
              init_done_reg <= 1'b1;
            end else begin
              step_reg <= step_reg + 3'd1;
            end
          end
        end
        ST_IDLE: begin
          if (pkt_start) begin
            if (len_bad) begin
              tx_err_reg <= 1'b1;
            end else begin
              len_reg   <= pkt_len;
              words_reg <= len_plus1[11:1];
              busy_reg  <= 1'b1;
              state_reg <= ST_MWCMD;
              step_reg  <= 3'd0;
            end
          end
        end
        ST_MWCMD: begin
          if (bus_done) begin
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus_start) begin
            words_reg <= words_reg - 11'd1;
          end
          // The handshake and a completion never coincide: the handshake needs an idle bus.
          if (bus_done && (words_reg == 11'd0)) begin
            state_reg    <= ST_POLL;
            step_reg     <= 3'd0;
            poll_cnt_reg <= 32'd0;
          end
        end
        ST_POLL: begin
          if (bus_done) begin
            if (step_reg == 3'd0) begin
              step_reg <= 3'd1;
            end else if (!tx_req_pending) begin
              state_reg <= ST_LEN;
              step_reg  <= 3'd0;
            end else if ((poll_cnt_reg + 32'd1) >= POLL_LIMIT) begin
              tx_err_reg <= 1'b1;
              busy_reg   <= 1'b0;
              state_reg  <= ST_IDLE;
              step_reg   <= 3'd0;
            end else begin
              poll_cnt_reg <= poll_cnt_reg + 32'd1;
            end
          end
        end
        ST_LEN: begin
          if (bus_done) begin
            if (step_reg == 3'd3) begin
              state_reg <= ST_ISSUE;
              step_reg  <= 3'd0;
            end else begin
              step_reg <= step_reg + 3'd1;
            end
          end
        end
        ST_ISSUE: begin
          if (bus_done) begin
            if (step_reg == 3'd1) begin
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
              step_reg  <= 3'd0;
            end else begin
              step_reg <= step_reg + 3'd1;
            end
          end
        end
        default: begin
          state_reg <= ST_WAIT_PWR;
          step_reg  <= 3'd0;
        end
      endcase
    end
  end

  assign init_done = init_done_reg;
  assign busy      = busy_reg;
  assign tx_err    = tx_err_reg;

  dm9000a_bus_cycle #(
    .STROBE_CYCLES  (STROBE_CYCLES),
    .RECOVERY_CYCLES(RECOVERY_CYCLES)
  ) u_bus_cycle (
    .clk_30       (clk_30),
    .reset_n      (reset_n),
    .start        (bus_start),
    .rd           (bus_rd),
    .cmd          (bus_cmd),
    .wdata        (bus_wdata),
    .idle         (bus_idle),
    .cyc_done     (bus_done),
    .rdata        (bus_rdata),
    .enet_ior_n   (enet_ior_n),
    .enet_iow_n   (enet_iow_n),
    .enet_cmd     (enet_cmd),
    .enet_data_oe (enet_data_oe),
    .enet_data_out(enet_data_out),
    .enet_data_in (enet_data_in)
  );

endmodule

// File: tb/tb_dm9000a_tx_engine.sv
// Scoreboard bench for dm9000a_tx_engine: expected bus cycles are queued by each test
// and matched by a bus monitor as strobes appear; the monitor also models the TX status register.
module tb_dm9000a_tx_engine;

  localparam int unsigned P_PWR  = 40;
  localparam int unsigned P_STB  = 3;
  localparam int unsigned P_REC  = 2;
  localparam int unsigned P_MAX  = 1536;
  localparam int unsigned P_POLL = 8;

  typedef struct packed {
    logic        rd;
    logic        cmd;
    logic [15:0] data;
  } bus_txn_t;

  logic        clk_30 = 1'b0;
  logic        reset_n = 1'b0;
  logic        pkt_start = 1'b0;
  logic [10:0] pkt_len = 11'd0;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        init_done;
  logic        busy;
  logic        tx_err;
  logic        enet_ior_n;
  logic        enet_iow_n;
  logic        enet_cmd;
  logic        enet_data_oe;
  logic [15:0] enet_data_out;
  logic [15:0] enet_data_in = 16'h0000;

  int checks = 0;
  int failures = 0;
  int txn_cnt = 0;
  int err_cnt = 0;

  bus_txn_t    exp_q[$];
  logic [15:0] resp_q[$];

  logic [23:0] rst_exp = {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [23:0] rst_obs;
  assign rst_obs = {enet_iow_n, enet_ior_n, enet_cmd, enet_data_oe, enet_data_out,
                    tx_ready, init_done, busy, tx_err};

  always #5 clk_30 = ~clk_30;

  dm9000a_tx_engine #(
    .POWERUP_CYCLES (P_PWR),
    .STROBE_CYCLES  (P_STB),
    .RECOVERY_CYCLES(P_REC),
    .IMR_VALUE      (8'h80),
    .CSCR_VALUE     (8'h05),
    .MAX_LEN        (P_MAX),
    .POLL_LIMIT     (P_POLL)
  ) dut (
    .clk_30       (clk_30),
    .reset_n      (reset_n),
    .pkt_start    (pkt_start),
    .pkt_len      (pkt_len),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .init_done    (init_done),
    .busy         (busy),
    .tx_err       (tx_err),
    .enet_ior_n   (enet_ior_n),
    .enet_iow_n   (enet_iow_n),
    .enet_cmd     (enet_cmd),
    .enet_data_oe (enet_data_oe),
    .enet_data_out(enet_data_out),
    .enet_data_in (enet_data_in)
  );

  // Bus monitor: matches each strobe against the scoreboard and checks strobe/recovery widths.
  bit       prev_iow = 1'b1;
  bit       prev_ior = 1'b1;
  bit       err_prev = 1'b0;
  bit       seen_strobe = 1'b0;
  int       low_cnt = 0;
  int       high_cnt = 0;
  bus_txn_t mon_exp;

  always @(negedge clk_30) begin
    if (!reset_n) begin
      prev_iow    = 1'b1;
      prev_ior    = 1'b1;
      err_prev    = 1'b0;
      seen_strobe = 1'b0;
      low_cnt     = 0;
      high_cnt    = 0;
    end else begin
      if ((prev_iow && !enet_iow_n) || (prev_ior && !enet_ior_n)) begin
        txn_cnt++;
        $display("txn %0d: %s cmd=%0b oe=%0b data=%h", txn_cnt, (!enet_ior_n ? "RD" : "WR"),
                 enet_cmd, enet_data_oe, enet_data_out);
        if (seen_strobe) begin
          checks++;
          if (high_cnt < int'(P_REC)) begin
            failures++;
            $display("FAIL recovery_width: strobes high %0d clocks, required at least %0d", high_cnt, P_REC);
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_txn: got rd=%0b cmd=%0b data=%h, expected no bus cycle",
                   !enet_ior_n, enet_cmd, enet_data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if ((!enet_iow_n && !enet_ior_n) || (mon_exp.rd !== !enet_ior_n) || (mon_exp.cmd !== enet_cmd) ||
              (!mon_exp.rd && ((enet_data_out !== mon_exp.data) || (enet_data_oe !== 1'b1))) ||
              (mon_exp.rd && (enet_data_oe !== 1'b0))) begin
            failures++;
            $display("FAIL bus_txn %0d: got iow_n=%0b ior_n=%0b cmd=%0b oe=%0b data=%h, expected rd=%0b cmd=%0b data=%h",
                     txn_cnt, enet_iow_n, enet_ior_n, enet_cmd, enet_data_oe, enet_data_out,
                     mon_exp.rd, mon_exp.cmd, mon_exp.data);
          end
        end
        if (!enet_ior_n) begin
          enet_data_in = (resp_q.size() != 0) ? resp_q.pop_front() : 16'h0000;
        end
        low_cnt = 0;
      end
      if ((!prev_iow && enet_iow_n) || (!prev_ior && enet_ior_n)) begin
        checks++;
        if (low_cnt != int'(P_STB)) begin
          failures++;
          $display("FAIL strobe_width: strobe low %0d clocks, required %0d", low_cnt, P_STB);
        end
        high_cnt    = 0;
        seen_strobe = 1'b1;
      end
      if (!enet_iow_n || !enet_ior_n) low_cnt++;
      else high_cnt++;
      if (tx_err) begin
        err_cnt++;
        checks++;
        if (err_prev) begin
          failures++;
          $display("FAIL tx_err_pulse: tx_err high 2 consecutive clocks, required 1");
        end
      end
      prev_iow = enet_iow_n;
      prev_ior = enet_ior_n;
      err_prev = tx_err;
    end
  end

  task automatic push_wr(input logic cmd, input logic [15:0] d);
    exp_q.push_back({1'b0, cmd, d});
  endtask

  task automatic push_reg(input logic [7:0] addr, input logic [7:0] val);
    push_wr(1'b0, {8'h00, addr});
    push_wr(1'b1, {8'h00, val});
  endtask

  // Releases reset (which must be asserted) and waits for the init sequence.
  task automatic do_init();
    int n;
    int c0;
    push_reg(8'hFF, 8'h80);
    push_reg(8'h1F, 8'h00);
    push_reg(8'h31, 8'h05);
    c0 = txn_cnt;
    @(posedge clk_30);
    #1 reset_n = 1'b1;
    repeat (30) @(negedge clk_30);
    checks++;
    if ((txn_cnt != c0) || (init_done !== 1'b0)) begin
      failures++;
      $display("FAIL powerup_quiet: txns=%0d init_done=%0b, required txns=%0d init_done=0",
               txn_cnt - c0, init_done, 0);
    end
    n = 0;
    while ((init_done !== 1'b1) && (n < 1000)) begin
      @(negedge clk_30);
      n++;
    end
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL init_done_timeout: init_done=%0b, required 1", init_done);
    end
    checks++;
    if ((exp_q.size() != 0) || (enet_iow_n !== 1'b1) || (txn_cnt - c0 != 6)) begin
      failures++;
      $display("FAIL init_seq: pending=%0d iow_n=%0b txns=%0d, required pending=0 iow_n=1 txns=6",
               exp_q.size(), enet_iow_n, txn_cnt - c0);
    end
    exp_q.delete();
  endtask

  task automatic send_packet(input int len, input int stall_at, input int poll_ones,
                             input bit inject, input int abort_at);
    logic [15:0] words[$];
    logic [10:0] l11;
    int nw;
    int n;
    int e0;
    int c0;
    int reads;
    bit timeout;
    l11     = len[10:0];
    nw      = (len + 1) / 2;
    timeout = (poll_ones >= int'(P_POLL));
    reads   = timeout ? int'(P_POLL) : poll_ones + 1;
    for (int i = 0; i < nw; i++) words.push_back(16'($urandom));
    push_wr(1'b0, 16'h00F8);
    for (int i = 0; i < nw; i++) push_wr(1'b1, words[i]);
    push_wr(1'b0, 16'h0002);
    for (int k = 0; k < reads; k++) exp_q.push_back({1'b1, 1'b1, 16'h0000});
    for (int k = 0; k < poll_ones && k < int'(P_POLL); k++) resp_q.push_back(16'hFF01);
    if (!timeout) begin
      resp_q.push_back(16'hFFFE);
      push_reg(8'hFC, l11[7:0]);
      push_reg(8'hFD, {5'b00000, l11[10:8]});
      push_reg(8'h02, 8'h01);
    end
    e0 = err_cnt;
    $display("packet len=%0d words=%0d poll_ones=%0d", len, nw, poll_ones);
    @(posedge clk_30);
    #1 pkt_len = l11;
    pkt_start = 1'b1;
    @(posedge clk_30);
    #1 pkt_start = 1'b0;
    checks++;
    if ((busy !== 1'b1) || (enet_iow_n !== 1'b1)) begin
      failures++;
      $display("FAIL start_accept: busy=%0b iow_n=%0b, required busy=1 iow_n=1", busy, enet_iow_n);
    end
    @(posedge clk_30);
    #1;
    checks++;
    if ((enet_iow_n !== 1'b0) || (enet_data_out !== 16'h00F8)) begin
      failures++;
      $display("FAIL start_latency: iow_n=%0b data=%h, required iow_n=0 data=00f8", enet_iow_n, enet_data_out);
    end
    for (int i = 0; i < nw; i++) begin
      if (i == abort_at) begin
        repeat (2) @(posedge clk_30);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (rst_obs !== rst_exp) begin
          failures++;
          $display("FAIL async_reset: outputs=%h, required %h", rst_obs, rst_exp);
        end
        exp_q.delete();
        resp_q.delete();
        tx_valid = 1'b0;
        return;
      end
      if (i == stall_at) begin
        repeat (8) @(posedge clk_30);
        #1 c0 = txn_cnt;
        repeat (12) @(posedge clk_30);
        #1;
        checks++;
        if ((txn_cnt != c0) || (enet_iow_n !== 1'b1) || (tx_ready !== 1'b1)) begin
          failures++;
          $display("FAIL stall_idle: new txns=%0d iow_n=%0b tx_ready=%0b, required 0 1 1",
                   txn_cnt - c0, enet_iow_n, tx_ready);
        end
      end
      if (inject && (i == nw / 2)) begin
        pkt_len   = 11'd0;
        pkt_start = 1'b1;
        @(posedge clk_30);
        #1 pkt_start = 1'b0;
        pkt_len = l11;
      end
      tx_data  = words[i];
      tx_valid = 1'b1;
      n = 0;
      @(negedge clk_30);
      while (!tx_ready && (n < 300)) begin
        @(negedge clk_30);
        n++;
      end
      if (!tx_ready) begin
        checks++;
        failures++;
        $display("FAIL tx_ready_timeout: word %0d tx_ready=%0b, required 1", i, tx_ready);
        tx_valid = 1'b0;
        exp_q.delete();
        resp_q.delete();
        return;
      end
      @(posedge clk_30);
      #1 tx_valid = 1'b0;
    end
    n = 0;
    while ((busy !== 1'b0) && (n < 5000)) begin
      @(negedge clk_30);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_stuck: busy=%0b, required 0", busy);
    end
    repeat (4) @(negedge clk_30);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_txns: %0d expected bus cycles not seen, required 0", exp_q.size());
    end
    checks++;
    if (err_cnt != e0 + (timeout ? 1 : 0)) begin
      failures++;
      $display("FAIL tx_err_count: pulses=%0d, required %0d", err_cnt - e0, timeout ? 1 : 0);
    end
    exp_q.delete();
    resp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_30);
    checks++;
    if (rst_obs !== rst_exp) begin
      failures++;
      $display("FAIL reset_values: outputs=%h, required %h", rst_obs, rst_exp);
    end
    do_init();
  endtask

  task automatic test_even_packet();
    send_packet(60, -1, 0, 1'b0, -1);
  endtask

  task automatic test_odd_packet();
    send_packet(61, -1, 0, 1'b0, -1);
    send_packet(1, -1, 0, 1'b0, -1);
  endtask

  task automatic test_poll_retry();
    send_packet(8, -1, 3, 1'b0, -1);
  endtask

  task automatic test_poll_timeout();
    int c0;
    send_packet(8, -1, int'(P_POLL), 1'b0, -1);
    c0 = txn_cnt;
    repeat (20) @(negedge clk_30);
    checks++;
    if ((txn_cnt != c0) || (busy !== 1'b0)) begin
      failures++;
      $display("FAIL timeout_quiet: new txns=%0d busy=%0b, required 0 0", txn_cnt - c0, busy);
    end
  endtask

  task automatic test_len_errors();
    logic [10:0] bad_lens[2];
    int c0;
    int e0;
    bad_lens[0] = 11'd0;
    bad_lens[1] = 11'd1537;
    for (int k = 0; k < 2; k++) begin
      c0 = txn_cnt;
      e0 = err_cnt;
      @(posedge clk_30);
      #1 pkt_len = bad_lens[k];
      pkt_start = 1'b1;
      @(posedge clk_30);
      #1 pkt_start = 1'b0;
      checks++;
      if ((tx_err !== 1'b1) || (busy !== 1'b0)) begin
        failures++;
        $display("FAIL len_reject %0d: tx_err=%0b busy=%0b, required 1 0", bad_lens[k], tx_err, busy);
      end
      repeat (10) @(negedge clk_30);
      checks++;
      if ((txn_cnt != c0) || (err_cnt != e0 + 1) || (tx_err !== 1'b0)) begin
        failures++;
        $display("FAIL len_reject_quiet %0d: txns=%0d pulses=%0d tx_err=%0b, required 0 1 0",
                 bad_lens[k], txn_cnt - c0, err_cnt - e0, tx_err);
      end
    end
  endtask

  task automatic test_stall_and_ignore();
    send_packet(20, 5, 1, 1'b1, -1);
  endtask

  task automatic test_max_len();
    send_packet(int'(P_MAX), -1, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    send_packet(40, -1, 0, 1'b0, 4);
    do_init();
    send_packet(10, -1, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_even_packet();
    test_odd_packet();
    test_poll_retry();
    test_poll_timeout();
    test_len_errors();
    test_stall_and_ignore();
    test_max_len();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
